write_clip_multi: RTL and testbench



---
 rtl/write_clip_multi.sv | 193 +++++++++++++++++++
 tb/tb_write_clip_multi.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/write_clip_multi.sv
// Tail stage of the convolution pipeline: buffers packed multi-lane results in a FIFO,
// saturates each lane to the output width and writes them to blockram at strided addresses.
module write_clip_multi #(
   parameter int NUM_CHANNELS           = 4,
   parameter int DATA_WIDTH             = 16,
   parameter int OUTPUT_DATA_WIDTH      = 8,
   parameter int FIFO_DEPTH             = 8,
   parameter int LOG_FIFO_DEPTH         = 3,
   parameter int LOG_MAX_ITERS          = 16,
   parameter int LOG_MAX_READS_PER_ITER = 16,
   parameter int LOG_MAX_ADDRESS        = 16
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      configure,
   input  logic [LOG_MAX_ITERS-1:0]                  num_iters,
   input  logic [LOG_MAX_READS_PER_ITER-1:0]         num_reads_per_iter,
   input  logic [LOG_MAX_ADDRESS-1:0]                base_address,
   input  logic [LOG_MAX_ADDRESS-1:0]                iter_stride,
   input  logic [OUTPUT_DATA_WIDTH-1:0]              min_clip,
   input  logic [OUTPUT_DATA_WIDTH-1:0]              max_clip,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]        data_in,
   input  logic                                      valid_in,
   output logic                                      avail_out,
   output logic [NUM_CHANNELS*OUTPUT_DATA_WIDTH-1:0] data_out,
   output logic [LOG_MAX_ADDRESS-1:0]                address_out,
   output logic                                      valid_out,
   input  logic                                      avail_in,
   output logic                                      done,
   output logic                                      error
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;

   localparam logic [LOG_FIFO_DEPTH:0] DEPTH_C = FIFO_DEPTH[LOG_FIFO_DEPTH:0];
   localparam logic [LOG_FIFO_DEPTH:0] AFULL_C = DEPTH_C - (LOG_FIFO_DEPTH+1)'(2);
   localparam logic [LOG_MAX_ITERS-1:0]          ITER_ONE_C = LOG_MAX_ITERS'(1);
   localparam logic [LOG_MAX_READS_PER_ITER-1:0] READ_ONE_C = LOG_MAX_READS_PER_ITER'(1);

   state_t                                state_r, state_nxt_s;
   logic [NUM_CHANNELS*DATA_WIDTH-1:0]    fifo_mem_r [FIFO_DEPTH];
   logic [LOG_FIFO_DEPTH-1:0]             wr_ptr_r, rd_ptr_r;
   logic [LOG_FIFO_DEPTH:0]               count_r;
   logic [LOG_MAX_ITERS-1:0]              iters_left_r;
   logic [LOG_MAX_READS_PER_ITER-1:0]     reads_r, words_left_r;
   logic [LOG_MAX_ADDRESS-1:0]            stride_r, iter_base_r, cur_addr_r;
   logic [OUTPUT_DATA_WIDTH-1:0]          min_r, max_r;
   logic                                  error_r;
   logic                                  run_s, full_s, empty_s, afull_s, push_s, pop_s;
   logic                                  last_word_s, last_iter_s;
   logic [NUM_CHANNELS*DATA_WIDTH-1:0]    head_s;

   // Signed saturation of one lane; an inverted bound pair resolves to max_clip on the upper test.
   function automatic logic [OUTPUT_DATA_WIDTH-1:0] clip_lane(
      input logic signed [DATA_WIDTH-1:0]        lane,
      input logic        [OUTPUT_DATA_WIDTH-1:0] lo,
      input logic        [OUTPUT_DATA_WIDTH-1:0] hi
   );
      logic signed [DATA_WIDTH-1:0] lo_x, hi_x;
      lo_x = {{(DATA_WIDTH-OUTPUT_DATA_WIDTH){lo[OUTPUT_DATA_WIDTH-1]}}, lo};
      hi_x = {{(DATA_WIDTH-OUTPUT_DATA_WIDTH){hi[OUTPUT_DATA_WIDTH-1]}}, hi};
      if (lane > hi_x) begin
         clip_lane = hi;
      end else if (lane < lo_x) begin
         clip_lane = lo;
      end else begin
         clip_lane = lane[OUTPUT_DATA_WIDTH-1:0];
      end
   endfunction

   assign run_s       = (state_r == ST_RUN);
   assign full_s      = (count_r == DEPTH_C);
   assign empty_s     = (count_r == '0);
   assign afull_s     = (count_r >= AFULL_C);
   assign pop_s       = run_s & ~empty_s & avail_in;
   // A pop in the same cycle frees the slot, so a write at full is still accepted then.
   assign push_s      = valid_in & run_s & (~full_s | pop_s);
   assign last_word_s = (words_left_r == READ_ONE_C);
   assign last_iter_s = (iters_left_r == ITER_ONE_C);
   assign head_s      = fifo_mem_r[rd_ptr_r];
   assign address_out = cur_addr_r;
   assign error       = error_r;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (configure) state_nxt_s = ST_RUN;
            else           state_nxt_s = ST_IDLE;
         end
         ST_RUN: begin
            if (pop_s & last_word_s & last_iter_s) state_nxt_s = ST_DONE;
            else                                   state_nxt_s = ST_RUN;
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      valid_out = 1'b0;
      avail_out = 1'b0;
      done      = 1'b0;
      case (state_r)
         ST_RUN: begin
            valid_out = pop_s;
            avail_out = ~afull_s;
         end
         ST_DONE: done = 1'b1;
         default: done = 1'b0;
      endcase
   end

   // FIFO storage (contents need no reset; occupancy is tracked separately).
   always_ff @(posedge clk) begin
      if (push_s) fifo_mem_r[wr_ptr_r] <= data_in;
   end

   // FIFO pointers and occupancy; leftovers are flushed once the job completes.
   always_ff @(posedge clk) begin
      if (rst || state_r == ST_DONE) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + LOG_FIFO_DEPTH'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + LOG_FIFO_DEPTH'(1);
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (LOG_FIFO_DEPTH+1)'(1);
            2'b01:   count_r <= count_r - (LOG_FIFO_DEPTH+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Configuration latch, iteration/word counters and write address generation.
   always_ff @(posedge clk) begin
      if (rst) begin
         iters_left_r <= '0;
         reads_r      <= '0;
         words_left_r <= '0;
         stride_r     <= '0;
         iter_base_r  <= '0;
         cur_addr_r   <= '0;
         min_r        <= '0;
         max_r        <= '0;
         error_r      <= 1'b0;
      end else begin
         if ((valid_in & ~push_s) | (configure & (state_r != ST_IDLE))) error_r <= 1'b1;
         if (state_r == ST_IDLE && configure) begin
            iters_left_r <= (num_iters == '0) ? ITER_ONE_C : num_iters;
            reads_r      <= (num_reads_per_iter == '0) ? READ_ONE_C : num_reads_per_iter;
            words_left_r <= (num_reads_per_iter == '0) ? READ_ONE_C : num_reads_per_iter;
            stride_r     <= iter_stride;
            iter_base_r  <= base_address;
            cur_addr_r   <= base_address;
            min_r        <= min_clip;
            max_r        <= max_clip;
         end else if (pop_s) begin
            if (last_word_s) begin
               words_left_r <= reads_r;
               iters_left_r <= iters_left_r - ITER_ONE_C;
               iter_base_r  <= iter_base_r + stride_r;
               cur_addr_r   <= iter_base_r + stride_r;
            end else begin
               words_left_r <= words_left_r - READ_ONE_C;
               cur_addr_r   <= cur_addr_r + LOG_MAX_ADDRESS'(1);
            end
         end
      end
   end

   // Per-lane clip of the FIFO head.
   always_comb begin
      data_out = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         data_out[i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH] =
            clip_lane(head_s[i*DATA_WIDTH +: DATA_WIDTH], min_r, max_r);
      end
   end

endmodule

// File: tb/tb_write_clip_multi.sv
// Directed self-checking bench for write_clip_multi with default parameters.
module tb_write_clip_multi;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        configure = 1'b0;
   logic [15:0] num_iters = 16'h0000, num_reads_per_iter = 16'h0000;
   logic [15:0] base_address = 16'h0000, iter_stride = 16'h0000;
   logic [7:0]  min_clip = 8'h00, max_clip = 8'h00;
   logic [63:0] data_in = 64'h0;
   logic        valid_in = 1'b0;
   logic        avail_out;
   logic [31:0] data_out;
   logic [15:0] address_out;
   logic        valid_out;
   logic        avail_in = 1'b0;
   logic        done;
   logic        error;

   int          n_checks = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   int          done_cyc = 0;
   int          last_write_cyc = 0;
   logic [15:0] wq_addr [$];
   logic [31:0] wq_data [$];

   write_clip_multi dut (
      .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
      .num_reads_per_iter(num_reads_per_iter), .base_address(base_address),
      .iter_stride(iter_stride), .min_clip(min_clip), .max_clip(max_clip),
      .data_in(data_in), .valid_in(valid_in), .avail_out(avail_out),
      .data_out(data_out), .address_out(address_out), .valid_out(valid_out),
      .avail_in(avail_in), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   // Cycle counter.
   always @(posedge clk) cyc <= cyc + 1;

   // Write monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (valid_out === 1'b1) begin
         wq_addr.push_back(address_out);
         wq_data.push_back(data_out);
         last_write_cyc <= cyc;
      end
      if (done === 1'b1) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] pin(input int l3, input int l2, input int l1, input int l0);
      return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
   endfunction

   function automatic logic [31:0] pout(input int l3, input int l2, input int l1, input int l0);
      return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      valid_in = 1'b0;
      configure = 1'b0;
      avail_in = 1'b0;
      step();
      step();
      rst = 1'b0;
      wq_addr.delete();
      wq_data.delete();
   endtask

   task automatic do_config(input logic [15:0] it, input logic [15:0] rd, input logic [15:0] ba,
                            input logic [15:0] st, input logic [7:0] mn, input logic [7:0] mx);
      num_iters = it;
      num_reads_per_iter = rd;
      base_address = ba;
      iter_stride = st;
      min_clip = mn;
      max_clip = mx;
      configure = 1'b1;
      step();
      configure = 1'b0;
   endtask

   task automatic send_word(input logic [63:0] d);
      data_in = d;
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int start;
      start = done_cnt;
      for (int i = 0; i < 60 && done_cnt == start; i++) step();
      repeat (3) step();
      check_eq(tag, 64'(done_cnt - start), 64'd1);
   endtask

   initial begin
      logic [15:0] exp_a [6];
      exp_a = '{16'h0010, 16'h0011, 16'h0012, 16'h0030, 16'h0031, 16'h0032};

      // Reset state
      do_reset();
      check_eq("rst_valid_out", 64'(valid_out), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_error", 64'(error), 64'd0);
      check_eq("rst_address", 64'(address_out), 64'd0);
      check_eq("rst_avail_out", 64'(avail_out), 64'd0);

      // Basic run: 2 iterations x 3 words, strided bases
      do_config(16'd2, 16'd3, 16'h0010, 16'h0020, 8'hF8, 8'h07);
      check_eq("basic_avail_out", 64'(avail_out), 64'd1);
      avail_in = 1'b1;
      for (int i = 0; i < 6; i++) send_word(pin(3, 3, 3, 3));
      wait_done("basic_done_once");
      check_eq("basic_nwrites", 64'(wq_addr.size()), 64'd6);
      for (int i = 0; i < 6; i++) begin
         check_eq($sformatf("basic_addr%0d", i), 64'(wq_addr[i]), 64'(exp_a[i]));
         check_eq($sformatf("basic_data%0d", i), 64'(wq_data[i]), 64'(pout(3, 3, 3, 3)));
      end
      check_eq("basic_done_timing", 64'(done_cyc), 64'(last_write_cyc + 1));
      check_eq("basic_error", 64'(error), 64'd0);

      // Clipping under normal, wide and inverted bounds
      do_config(16'd1, 16'd1, 16'h0040, 16'h0000, 8'hF8, 8'h07);
      send_word(pin(100, -100, 7, -8));
      wait_done("clip1_done");
      do_config(16'd1, 16'd1, 16'h0041, 16'h0000, 8'h9C, 8'h64);
      send_word(pin(-50, 50, 300, -300));
      wait_done("clip2_done");
      do_config(16'd1, 16'd1, 16'h0042, 16'h0000, 8'h05, 8'hFB);
      send_word(pin(0, -10, -5, 20));
      wait_done("clip3_done");
      check_eq("clip_nwrites", 64'(wq_data.size()), 64'd9);
      check_eq("clip_sat", 64'(wq_data[6]), 64'(pout(7, -8, 7, -8)));
      check_eq("clip_pass", 64'(wq_data[7]), 64'(pout(-50, 50, 100, -100)));
      check_eq("clip_inverted", 64'(wq_data[8]), 64'(pout(-5, 5, 5, -5)));

      // Backpressure: 8 words held while avail_in is low
      do_reset();
      do_config(16'd1, 16'd8, 16'h0100, 16'h0000, 8'h80, 8'h7F);
      for (int k = 0; k < 8; k++) begin
         send_word(pin(k, k + 10, -k, -(k + 10)));
         if (k == 4) check_eq("bp_avail_at5", 64'(avail_out), 64'd1);
         if (k == 5) check_eq("bp_avail_at6", 64'(avail_out), 64'd0);
      end
      check_eq("bp_avail_at8", 64'(avail_out), 64'd0);
      check_eq("bp_no_writes", 64'(wq_addr.size()), 64'd0);
      avail_in = 1'b1;
      wait_done("bp_done");
      check_eq("bp_nwrites", 64'(wq_addr.size()), 64'd8);
      for (int k = 0; k < 8; k++) begin
         check_eq($sformatf("bp_addr%0d", k), 64'(wq_addr[k]), 64'(16'h0100 + 16'(k)));
         check_eq($sformatf("bp_data%0d", k), 64'(wq_data[k]), 64'(pout(k, k + 10, -k, -(k + 10))));
      end
      check_eq("bp_error", 64'(error), 64'd0);

      // Overflow: 9th word into a full FIFO is dropped
      do_reset();
      do_config(16'd1, 16'd9, 16'h0080, 16'h0000, 8'h80, 8'h7F);
      for (int k = 0; k < 8; k++) send_word(pin(k + 1, 0, 0, 0));
      check_eq("ovf_error_before", 64'(error), 64'd0);
      send_word(pin(99, 0, 0, 0));
      check_eq("ovf_error_set", 64'(error), 64'd1);
      avail_in = 1'b1;
      repeat (12) step();
      check_eq("ovf_error_sticky", 64'(error), 64'd1);
      check_eq("ovf_nwrites", 64'(wq_addr.size()), 64'd8);
      check_eq("ovf_last_data", 64'(wq_data[7]), 64'(pout(8, 0, 0, 0)));
      do_reset();
      check_eq("ovf_error_cleared", 64'(error), 64'd0);

      // Configure during RUN is ignored and flagged
      do_config(16'd1, 16'd4, 16'h0200, 16'h0000, 8'h80, 8'h7F);
      avail_in = 1'b1;
      send_word(pin(1, 1, 1, 1));
      do_config(16'd3, 16'd1, 16'h0500, 16'h0010, 8'h00, 8'h00);
      check_eq("cfg_error", 64'(error), 64'd1);
      for (int k = 0; k < 3; k++) send_word(pin(2, 2, 2, 2));
      wait_done("cfg_done");
      check_eq("cfg_nwrites", 64'(wq_addr.size()), 64'd4);
      for (int k = 0; k < 4; k++)
         check_eq($sformatf("cfg_addr%0d", k), 64'(wq_addr[k]), 64'(16'h0200 + 16'(k)));
      check_eq("cfg_data_bounds", 64'(wq_data[3]), 64'(pout(2, 2, 2, 2)));

      // Reset with 3 words buffered
      do_reset();
      do_config(16'd1, 16'd8, 16'h0300, 16'h0000, 8'h80, 8'h7F);
      for (int k = 0; k < 3; k++) send_word(pin(5, 5, 5, 5));
      rst = 1'b1;
      step();
      rst = 1'b0;
      avail_in = 1'b1;
      check_eq("mrst_valid_out", 64'(valid_out), 64'd0);
      check_eq("mrst_avail_out", 64'(avail_out), 64'd0);
      repeat (5) step();
      check_eq("mrst_no_writes", 64'(wq_addr.size()), 64'd0);

      // Zero counts treated as 1, address wrap
      do_reset();
      avail_in = 1'b1;
      do_config(16'd0, 16'd0, 16'hFFFF, 16'h1234, 8'hF8, 8'h07);
      send_word(pin(1, 2, -3, 4));
      wait_done("zero_done");
      check_eq("zero_nwrites", 64'(wq_addr.size()), 64'd1);
      check_eq("zero_addr", 64'(wq_addr[0]), 64'h0000_0000_0000_FFFF);
      check_eq("zero_data", 64'(wq_data[0]), 64'(pout(1, 2, -3, 4)));
      do_config(16'd1, 16'd2, 16'hFFFF, 16'h0000, 8'hF8, 8'h07);
      send_word(pin(0, 0, 0, 0));
      send_word(pin(0, 0, 0, 0));
      wait_done("wrap_done");
      check_eq("wrap_nwrites", 64'(wq_addr.size()), 64'd3);
      check_eq("wrap_addr0", 64'(wq_addr[1]), 64'h0000_0000_0000_FFFF);
      check_eq("wrap_addr1", 64'(wq_addr[2]), 64'd0);
      check_eq("wrap_error", 64'(error), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
